// File: rtl/label_resolver_pkg.sv
// Shared types for the label_resolver union-find engine.
package label_resolver_pkg;

  // Width of the labels carried in a queued merge; label_resolver's LABEL_WIDTH must match it.
  localparam int LR_LABEL_WIDTH = 8;

  typedef enum logic [2:0] {
    IDLE,
    M_FIND_A,
    M_FIND_B,
    M_LINK,
    R_FIND,
    R_DONE,
    FLUSH
  } lr_state_t;

  typedef struct packed {
    logic [LR_LABEL_WIDTH-1:0] a;
    logic [LR_LABEL_WIDTH-1:0] b;
  } merge_req_t;

endpackage

// File: rtl/lr_merge_fifo.sv
// Small synchronous FIFO buffering merge requests ahead of the root walker.
module lr_merge_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  // The extra pointer bit tells a full buffer apart from an empty one.
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop && !empty) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/label_resolver.sv
// Sequential union-find: queued merges and handshaked resolves, one parent hop per cycle.
module label_resolver
  import label_resolver_pkg::*;
#(
  parameter int LABEL_WIDTH      = LR_LABEL_WIDTH,
  parameter int MAX_PATH_DEPTH   = 8,
  parameter int MERGE_FIFO_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   frame_end,
  input  logic                   merge_valid,
  output logic                   merge_ready,
  input  logic [LABEL_WIDTH-1:0] merge_a,
  input  logic [LABEL_WIDTH-1:0] merge_b,
  input  logic                   resolve_valid,
  output logic                   resolve_ready,
  input  logic [LABEL_WIDTH-1:0] resolve_label,
  output logic                   resolved_valid,
  output logic [LABEL_WIDTH-1:0] resolved_label,
  output logic                   busy,
  output logic                   depth_err
);

  localparam int NUM_LABELS = 2**LABEL_WIDTH;
  localparam int HOP_W      = $clog2(MAX_PATH_DEPTH + 1);

  lr_state_t state, state_nxt;

  logic [LABEL_WIDTH-1:0] parent [NUM_LABELS];
  logic [NUM_LABELS-1:0]  valid;

  logic [LABEL_WIDTH-1:0] cur, cur_nxt, b_q, b_nxt, ra, ra_nxt, orig, orig_nxt;
  logic [HOP_W-1:0]       hops, hops_nxt;
  logic                   flush_pending, flush_nxt, depth_err_nxt;
  logic                   wr_en, clear_valid;
  logic [LABEL_WIDTH-1:0] wr_addr, wr_data, p_cur;
  logic                   at_root, depth_hit;
  logic                   fifo_push, fifo_pop, fifo_full, fifo_empty;
  merge_req_t             push_req, head;

  assign push_req  = '{a: merge_a, b: merge_b};
  assign fifo_push = merge_valid && merge_ready;

  lr_merge_fifo #(
    .WIDTH($bits(merge_req_t)),
    .DEPTH(MERGE_FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (fifo_push),
    .push_data(push_req),
    .pop      (fifo_pop),
    .pop_data (head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // An entry never written since the last clear is its own parent.
  assign p_cur     = valid[cur] ? parent[cur] : cur;
  assign at_root   = (p_cur == cur);
  assign depth_hit = (hops == HOP_W'(MAX_PATH_DEPTH));

  assign merge_ready   = rst_n && !fifo_full && !flush_pending;
  assign resolve_ready = rst_n && (state == IDLE) && fifo_empty && !flush_pending && !merge_valid;
  assign busy          = (state != IDLE) || !fifo_empty || flush_pending;

  always_comb begin
    state_nxt      = state;
    cur_nxt        = cur;
    hops_nxt       = hops;
    b_nxt          = b_q;
    ra_nxt         = ra;
    orig_nxt       = orig;
    depth_err_nxt  = depth_err;
    flush_nxt      = flush_pending || frame_end;
    fifo_pop       = 1'b0;
    wr_en          = 1'b0;
    wr_addr        = '0;
    wr_data        = '0;
    clear_valid    = 1'b0;
    resolved_valid = 1'b0;
    resolved_label = '0;

    case (state)
      IDLE: begin
        if (flush_pending && fifo_empty) begin
          state_nxt = FLUSH;
        end else if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          cur_nxt   = head.a;
          b_nxt     = head.b;
          hops_nxt  = '0;
          state_nxt = M_FIND_A;
        end else if (resolve_valid && resolve_ready) begin
          cur_nxt   = resolve_label;
          orig_nxt  = resolve_label;
          hops_nxt  = '0;
          state_nxt = R_FIND;
        end
      end
      // A walk ends at a true root or, past the depth limit, at the current node.
      M_FIND_A, M_FIND_B, R_FIND: begin
        if (at_root || depth_hit) begin
          if (!at_root) depth_err_nxt = 1'b1;
          if (state == M_FIND_A) begin
            ra_nxt    = cur;
            cur_nxt   = b_q;
            hops_nxt  = '0;
            state_nxt = M_FIND_B;
          end else if (state == M_FIND_B) begin
            state_nxt = M_LINK;
          end else begin
            state_nxt = R_DONE;
          end
        end else begin
          cur_nxt  = p_cur;
          hops_nxt = hops + HOP_W'(1);
        end
      end
      M_LINK: begin
        if (ra != cur) begin
          wr_en   = 1'b1;
          wr_addr = (ra > cur) ? ra : cur;
          wr_data = (ra > cur) ? cur : ra;
        end
        state_nxt = IDLE;
      end
      R_DONE: begin
        resolved_valid = 1'b1;
        resolved_label = cur;
        if (orig != cur) begin
          wr_en   = 1'b1;
          wr_addr = orig;
          wr_data = cur;
        end
        state_nxt = IDLE;
      end
      FLUSH: begin
        clear_valid = 1'b1;
        flush_nxt   = 1'b0;
        state_nxt   = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      cur           <= '0;
      hops          <= '0;
      b_q           <= '0;
      ra            <= '0;
      orig          <= '0;
      flush_pending <= 1'b0;
      depth_err     <= 1'b0;
    end else begin
      state         <= state_nxt;
      cur           <= cur_nxt;
      hops          <= hops_nxt;
      b_q           <= b_nxt;
      ra            <= ra_nxt;
      orig          <= orig_nxt;
      flush_pending <= flush_nxt;
      depth_err     <= depth_err_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clear_valid) valid <= '0;
    else if (wr_en)            valid[wr_addr] <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (wr_en) parent[wr_addr] <= wr_data;
  end

endmodule

// File: tb/tb_label_resolver.sv
// Directed bench for label_resolver with a reference union-find model and per-cycle result check.
module tb_label_resolver;

  localparam int LW   = 8;
  localparam int NL   = 256;
  localparam int MAXD = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          frame_end = 1'b0;
  logic          merge_valid = 1'b0;
  logic          resolve_valid = 1'b0;
  logic [LW-1:0] merge_a = '0;
  logic [LW-1:0] merge_b = '0;
  logic [LW-1:0] resolve_label = '0;
  logic          merge_ready, resolve_ready, resolved_valid, busy, depth_err;
  logic [LW-1:0] resolved_label;

  int tests = 0;
  int fails = 0;
  int edges = 0;
  int last_accept = 0;

  int m_parent [NL];
  bit m_valid  [NL];
  bit m_err = 1'b0;

  typedef struct {
    int due;
    int root;
  } exp_t;
  exp_t exp_q [$];

  label_resolver #(
    .LABEL_WIDTH     (LW),
    .MAX_PATH_DEPTH  (MAXD),
    .MERGE_FIFO_DEPTH(4)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .frame_end     (frame_end),
    .merge_valid   (merge_valid),
    .merge_ready   (merge_ready),
    .merge_a       (merge_a),
    .merge_b       (merge_b),
    .resolve_valid (resolve_valid),
    .resolve_ready (resolve_ready),
    .resolve_label (resolve_label),
    .resolved_valid(resolved_valid),
    .resolved_label(resolved_label),
    .busy          (busy),
    .depth_err     (depth_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edges++;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d (edge %0d)", name, actual, expected, edges);
    end
  endtask

  // Reference model: a plain union-find table; smaller root wins, walks capped at MAXD hops.
  function automatic int m_p(input int x);
    return m_valid[x] ? m_parent[x] : x;
  endfunction

  task automatic m_find(input int x, output int root, output int hops);
    int c;
    c = x;
    hops = 0;
    while (m_p(c) != c) begin
      if (hops == MAXD) begin
        m_err = 1'b1;
        break;
      end
      c = m_p(c);
      hops++;
    end
    root = c;
  endtask

  task automatic m_merge(input int a, input int b);
    int ra, rb, ha, hb;
    m_find(a, ra, ha);
    m_find(b, rb, hb);
    if (ra != rb) begin
      m_parent[(ra > rb) ? ra : rb] = (ra > rb) ? rb : ra;
      m_valid[(ra > rb) ? ra : rb]  = 1'b1;
    end
  endtask

  task automatic m_clear();
    for (int i = 0; i < NL; i++) m_valid[i] = 1'b0;
  endtask

  // Compare on the falling edge, then sample handshakes just before the next rising edge.
  always @(negedge clk) begin
    bit   ev;
    int   el, r, h;
    exp_t e;
    if (rst_n) begin
      ev = (exp_q.size() > 0) && (exp_q[0].due == edges);
      el = ev ? exp_q[0].root : 0;
      checkOutput("resolved_valid", resolved_valid, ev);
      checkOutput("resolved_label", resolved_label, el);
      if (ev) void'(exp_q.pop_front());
    end
    #4;
    if (!rst_n) begin
      m_clear();
      m_err = 1'b0;
      exp_q.delete();
    end else begin
      if (merge_valid && merge_ready) m_merge(merge_a, merge_b);
      if (frame_end) m_clear();
      if (resolve_valid && resolve_ready) begin
        m_find(resolve_label, r, h);
        if (r != int'(resolve_label)) begin
          m_parent[resolve_label] = r;
          m_valid[resolve_label]  = 1'b1;
        end
        last_accept = edges + 1;
        e.due  = edges + 2 + h;
        e.root = r;
        exp_q.push_back(e);
      end
    end
  end

  task automatic applyStimulus(input logic mv, input int a, input int b,
                               input logic rv, input int rl, input logic fe);
    merge_valid   = mv;
    merge_a       = LW'(a);
    merge_b       = LW'(b);
    resolve_valid = rv;
    resolve_label = LW'(rl);
    frame_end     = fe;
  endtask

  task automatic pushMerge(input int a, input int b, output bit first_ready);
    bit acc;
    acc = 1'b0;
    first_ready = 1'b0;
    applyStimulus(1'b1, a, b, 1'b0, 0, 1'b0);
    for (int w = 0; w < 100 && !acc; w++) begin
      #4;
      if (w == 0) first_ready = merge_ready;
      acc = merge_ready;
      @(negedge clk);
    end
    if (!acc) checkOutput("merge_accept_timeout", 0, 1);
  endtask

  task automatic startResolve(input int label, output bit first_ready);
    bit acc;
    acc = 1'b0;
    first_ready = 1'b0;
    applyStimulus(1'b0, 0, 0, 1'b1, label, 1'b0);
    for (int w = 0; w < 100 && !acc; w++) begin
      #4;
      if (w == 0) first_ready = resolve_ready;
      acc = resolve_ready;
      @(negedge clk);
    end
    applyStimulus(1'b0, 0, 0, 1'b0, 0, 1'b0);
    if (!acc) checkOutput("resolve_accept_timeout", 0, 1);
  endtask

  task automatic waitResolved(output int lbl, output int lat);
    bit got;
    got = 1'b0;
    lbl = -1;
    lat = -1;
    for (int w = 0; w < 100 && !got; w++) begin
      if (resolved_valid) begin
        got = 1'b1;
        lbl = int'(resolved_label);
        lat = edges + 1 - last_accept;
      end else begin
        @(negedge clk);
      end
    end
    if (!got) checkOutput("resolve_result_timeout", 0, 1);
  endtask

  task automatic waitIdle();
    bit done;
    done = 1'b0;
    for (int w = 0; w < 200 && !done; w++) begin
      if (!busy) done = 1'b1;
      else @(negedge clk);
    end
    if (!done) checkOutput("busy_timeout", 0, 1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit fr;
    int lbl, lat, busy_cycles;
    int ma [5];
    int mb [5];
    bit acc;

    applyStimulus(1'b0, 0, 0, 1'b0, 0, 1'b0);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_merge_ready", merge_ready, 0);
    checkOutput("rst_resolve_ready", resolve_ready, 0);
    checkOutput("rst_resolved_valid", resolved_valid, 0);
    checkOutput("rst_resolved_label", resolved_label, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_depth_err", depth_err, 0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("merge_ready_after_reset", merge_ready, 1);
    checkOutput("resolve_ready_idle", resolve_ready, 1);

    // Untouched label resolves to itself with no hops.
    startResolve(5, fr);
    waitResolved(lbl, lat);
    checkOutput("resolve5_label", lbl, 5);
    checkOutput("resolve5_latency", lat, 2);
    checkOutput("resolve5_depth_err", depth_err, 0);

    pushMerge(3, 7, fr);
    pushMerge(7, 9, fr);
    applyStimulus(1'b0, 0, 0, 1'b0, 0, 1'b0);
    waitIdle();
    startResolve(9, fr);
    waitResolved(lbl, lat);
    checkOutput("resolve9_label", lbl, 3);
    checkOutput("resolve9_latency", lat, 3);
    startResolve(9, fr);
    waitResolved(lbl, lat);
    checkOutput("resolve9_again_label", lbl, 3);
    checkOutput("resolve9_again_latency", lat, 3);

    // Chain 29->28->...->20 is nine hops deep, one beyond the limit.
    for (int k = 28; k >= 20; k--) pushMerge(k, k + 1, fr);
    applyStimulus(1'b0, 0, 0, 1'b0, 0, 1'b0);
    waitIdle();
    startResolve(29, fr);
    waitResolved(lbl, lat);
    checkOutput("deep_resolve_label", lbl, 21);
    checkOutput("deep_resolve_latency", lat, 10);
    checkOutput("deep_depth_err", depth_err, 1);
    checkOutput("deep_depth_err_model", depth_err, m_err);

    // Keep the walker busy on 28 so five back-to-back merges overflow the 4-entry FIFO.
    ma = '{1, 1, 40, 41, 42};
    mb = '{40, 41, 42, 43, 44};
    startResolve(28, fr);
    for (int i = 0; i < 5; i++) begin
      pushMerge(ma[i], mb[i], fr);
      checkOutput($sformatf("merge%0d_first_ready", i), fr, (i < 4) ? 1 : 0);
    end
    startResolve(44, fr);
    checkOutput("resolve_blocked_by_fifo", fr, 0);
    waitResolved(lbl, lat);
    checkOutput("resolve44_label", lbl, 1);
    for (int k = 40; k <= 43; k++) begin
      startResolve(k, fr);
      waitResolved(lbl, lat);
      checkOutput($sformatf("resolve%0d_label", k), lbl, 1);
    end
    checkOutput("depth_err_sticky", depth_err, 1);

    // Merge in the same cycle as frame_end, then hold a resolve through the flush.
    waitIdle();
    applyStimulus(1'b1, 2, 6, 1'b0, 0, 1'b1);
    #4;
    checkOutput("merge_ready_at_frame_end", merge_ready, 1);
    @(negedge clk);
    applyStimulus(1'b0, 0, 0, 1'b1, 6, 1'b0);
    busy_cycles = 0;
    acc = 1'b0;
    for (int w = 0; w < 50 && !acc; w++) begin
      #4;
      if (resolve_ready) begin
        acc = 1'b1;
        checkOutput("merge_ready_after_flush", merge_ready, 1);
      end else begin
        busy_cycles++;
        checkOutput("busy_while_blocked", busy, 1);
        checkOutput("merge_ready_during_flush", merge_ready, 0);
      end
      @(negedge clk);
    end
    applyStimulus(1'b0, 0, 0, 1'b0, 0, 1'b0);
    checkOutput("flush_busy_cycles", busy_cycles, 6);
    waitResolved(lbl, lat);
    checkOutput("resolve6_after_flush", lbl, 6);
    startResolve(9, fr);
    waitResolved(lbl, lat);
    checkOutput("resolve9_after_flush", lbl, 9);

    // Reset in the middle of a long walk must drop the result and the table.
    for (int k = 58; k >= 50; k--) pushMerge(k, k + 1, fr);
    applyStimulus(1'b0, 0, 0, 1'b0, 0, 1'b0);
    waitIdle();
    startResolve(59, fr);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      checkOutput("no_pulse_after_reset", resolved_valid, 0);
    end
    checkOutput("busy_after_mid_reset", busy, 0);
    checkOutput("depth_err_after_reset", depth_err, 0);
    startResolve(59, fr);
    waitResolved(lbl, lat);
    checkOutput("resolve59_after_reset", lbl, 59);
    checkOutput("resolve59_latency", lat, 2);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
